matrix_cfg_switch: RTL
======================

Name: matrix_cfg_switch

Overview:
- Parametrised, runtime-configurable successor to the fixed switch matrix.
- N_WIRES routing tracks; each track is either undriven or driven by one other track.
- Configuration is written through a valid/ready port into a shadow bank, then committed atomically to the active bank.
- Tracks are split into in/out/oe vectors; pad tri-state lives at top level.

Parameters:
- N_WIRES, 18, number of routing tracks (2..255).
- SEL_W, $clog2(N_WIRES+1), select code width. Code 0 = undriven; code k = driven by track k-1.
- AW, $clog2(N_WIRES), config/readback address width.
- OUT_REG, 0, 1 = register wire_out/wire_oe (adds one cycle); 0 = combinational from active bank.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  write accepted when valid&&ready.
- cfg_addr  in  AW  track being configured.
- cfg_sel  in  SEL_W  select code for cfg_addr.
- cfg_commit  in  1  pulse: copy shadow to active.
- cfg_clear  in  1  pulse: zero shadow bank.
- cfg_busy  out  1  commit/clear in progress.
- cfg_err  out  1  one-cycle pulse on rejected write.
- cfg_err_sticky  out  1  set by any reject; cleared by clear or reset.
- commit_cnt  out  8  number of completed commits, wraps 255->0.
- rd_addr  in  AW  readback address.
- rd_sel  out  SEL_W  active-bank code at rd_addr, registered (1-cycle latency).
- wire_in  in  N_WIRES  current track values.
- wire_out  out  N_WIRES  driven value per track.
- wire_oe  out  N_WIRES  1 = track driven.

Behaviour:
- Reset (async assert, sync release):
  - Shadow and active banks all 0; state IDLE.
  - cfg_ready=0, cfg_busy=0, cfg_err=0, cfg_err_sticky=0, commit_cnt=0, rd_sel=0.
  - wire_oe=0, wire_out=0.
  - cfg_ready rises the first cycle after release.
- States: IDLE, COMMIT, CLEAR. cfg_ready=1 only in IDLE; cfg_busy=1 in COMMIT and CLEAR.
- IDLE write handling:
  - An accepted write updates shadow[cfg_addr] at the next edge.
  - Rejected, with cfg_err pulsed the next cycle and sticky set, if:
    - cfg_addr >= N_WIRES,
    - cfg_sel > N_WIRES, or
    - cfg_sel == cfg_addr+1 (self-drive).
  - A rejected write leaves the shadow bank unchanged.
- IDLE, cfg_commit=1: go to COMMIT. A write accepted in the same cycle is included in the commit.
- COMMIT (exactly 1 cycle): active <= shadow for all tracks simultaneously; commit_cnt++; return to IDLE.
- IDLE, cfg_clear=1: go to CLEAR and set counter idx=0. A same-cycle write is discarded without error. Clear has priority over commit.
- CLEAR:
  - Zeroes shadow[idx] each cycle; idx++.
  - After idx==N_WIRES-1, return to IDLE and clear cfg_err_sticky. Duration is N_WIRES cycles.
  - The active bank is untouched; routing continues.
- cfg_commit or cfg_clear while busy: ignored (not queued).
- Routing, for each track i:
  - wire_oe[i] = (active[i]!=0).
  - wire_out[i] = wire_oe[i] ? wire_in[active[i]-1] : 0.
  - With OUT_REG=1, both are registered.
- Multi-track combinational loops (A<-B, B<-A) are not detected; avoiding them is a software obligation.
- Reset mid-CLEAR or mid-COMMIT: everything returns to reset values; no partial commit remains visible.

Decomposition:
- Package matrix_pkg holds:
  - sel_w(n) function.
  - state enum {IDLE, COMMIT, CLEAR}.
  - SEL_NONE = 0.
  - COMMIT_CNT_W = 8.
- Sub-module matrix_route_mux: one instance per track. Takes the active select code and wire_in; produces out and oe.

Test Plan:
- Reset, write addr 2 sel 9, commit -> after COMMIT, wire_oe[2]=1 and wire_out[2] follows wire_in[8]; all other oe=0; commit_cnt=1.
- Write addr 4 sel 5 (self-drive) -> cfg_err pulses 1 cycle, sticky=1, shadow[4] stays 0; write addr 4 sel 19 (N=18) -> rejected likewise.
- Write addr 0 sel 3 without commit -> wire_oe[0] stays 0 and rd_sel(0)=0; after commit, rd_sel(0)=3 one cycle after rd_addr=0.
- Write and commit in the same cycle (addr 7 sel 1) -> active[7]=1 after COMMIT; cfg_ready=0 for exactly 1 cycle.
- Configure 3 tracks, commit, clear -> cfg_busy high 18 cycles, routing unchanged; second commit drives all oe to 0; sticky cleared; commit_cnt=2.
- Assert rst_n low during CLEAR cycle 5 -> all outputs 0 immediately; cfg_ready=1 the cycle after release.

Source files
------------

// File: rtl/matrix_cfg_switch_pkg.sv
// Shared types and constants for the runtime-configurable switch matrix.
package matrix_pkg;

  localparam int SEL_NONE     = 0;
  localparam int COMMIT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // Select code 0 means undriven, so codes run 0..n and need one extra value.
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/matrix_cfg_switch_if.sv
// Configuration, status and readback bus of the switch matrix.
interface matrix_cfg_switch_if
  import matrix_pkg::*;
#(
  parameter int N_WIRES = 18,
  parameter int SEL_W   = sel_w(N_WIRES),
  parameter int AW      = $clog2(N_WIRES)
) ();

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [AW-1:0]           cfg_addr;
  logic [SEL_W-1:0]        cfg_sel;
  logic                    cfg_commit;
  logic                    cfg_clear;
  logic                    cfg_busy;
  logic                    cfg_err;
  logic                    cfg_err_sticky;
  logic [COMMIT_CNT_W-1:0] commit_cnt;
  logic [AW-1:0]           rd_addr;
  logic [SEL_W-1:0]        rd_sel;

  modport master (
    output cfg_valid, cfg_addr, cfg_sel, cfg_commit, cfg_clear, rd_addr,
    input  cfg_ready, cfg_busy, cfg_err, cfg_err_sticky, commit_cnt, rd_sel
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_sel, cfg_commit, cfg_clear, rd_addr,
    output cfg_ready, cfg_busy, cfg_err, cfg_err_sticky, commit_cnt, rd_sel
  );

endinterface

// File: rtl/matrix_cfg_switch_route_mux.sv
// One routing track: picks the source track named by its select code.
module matrix_route_mux
  import matrix_pkg::*;
#(
  parameter int N_WIRES = 18,
  parameter int SEL_W   = sel_w(N_WIRES)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_WIRES-1:0] wire_in,
  output logic               out,
  output logic               oe
);

  // Out-of-range codes never reach the active bank, so they simply drive 0.
  always_comb begin
    out = 1'b0;
    oe  = (sel != SEL_W'(SEL_NONE));
    for (int k = 0; k < N_WIRES; k++) begin
      if (int'(sel) == k + 1) begin
        out = wire_in[k];
      end
    end
  end

endmodule

// File: rtl/matrix_cfg_switch.sv
// Runtime-configurable switch matrix: shadow/active select banks with
// atomic commit, sequential clear, registered readback and per-track routing.
module matrix_cfg_switch
  import matrix_pkg::*;
#(
  parameter int N_WIRES = 18,
  parameter int SEL_W   = sel_w(N_WIRES),
  parameter int AW      = $clog2(N_WIRES),
  parameter bit OUT_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_cfg_switch_if.slave cfg,
  input  logic [N_WIRES-1:0] wire_in,
  output logic [N_WIRES-1:0] wire_out,
  output logic [N_WIRES-1:0] wire_oe
);

  state_t                  state, state_nx;
  logic [SEL_W-1:0]        shadow [N_WIRES];
  logic [SEL_W-1:0]        active [N_WIRES];
  logic [AW-1:0]           idx;
  logic                    ready_q, err_q, sticky_q;
  logic [COMMIT_CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0]        rd_q;
  logic                    accept, bad_write, do_write, rejected;
  logic [N_WIRES-1:0]      mux_out, mux_oe;

  // ready_q is only ever high in IDLE, so accept implies IDLE.
  always_comb begin
    accept    = cfg.cfg_valid && ready_q;
    bad_write = (int'(cfg.cfg_addr) >= N_WIRES) ||
                (int'(cfg.cfg_sel) > N_WIRES) ||
                (int'(cfg.cfg_sel) == int'(cfg.cfg_addr) + 1);
    do_write  = accept && !cfg.cfg_clear && !bad_write;
    rejected  = accept && !cfg.cfg_clear && bad_write;
    state_nx  = state;
    case (state)
      IDLE: begin
        if (cfg.cfg_clear)       state_nx = CLEAR;
        else if (cfg.cfg_commit) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      CLEAR:   if (idx == AW'(N_WIRES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      idx      <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == IDLE);
      err_q   <= rejected;
      if (state == CLEAR && state_nx == IDLE) sticky_q <= 1'b0;
      else if (rejected)                      sticky_q <= 1'b1;
      if (state == COMMIT) cnt_q <= cnt_q + 1'b1;
      if (state == IDLE)       idx <= '0;
      else if (state == CLEAR) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WIRES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (do_write)       shadow[cfg.cfg_addr] <= cfg.cfg_sel;
      if (state == CLEAR) shadow[idx] <= '0;
      if (state == COMMIT) begin
        for (int i = 0; i < N_WIRES; i++) active[i] <= shadow[i];
      end
      rd_q <= (int'(cfg.rd_addr) < N_WIRES) ? active[cfg.rd_addr] : '0;
    end
  end

  assign cfg.cfg_ready      = ready_q;
  assign cfg.cfg_busy       = (state != IDLE);
  assign cfg.cfg_err        = err_q;
  assign cfg.cfg_err_sticky = sticky_q;
  assign cfg.commit_cnt     = cnt_q;
  assign cfg.rd_sel         = rd_q;

  for (genvar g = 0; g < N_WIRES; g++) begin : g_track
    matrix_route_mux #(.N_WIRES(N_WIRES), .SEL_W(SEL_W)) u_mux (
      .sel     (active[g]),
      .wire_in (wire_in),
      .out     (mux_out[g]),
      .oe      (mux_oe[g])
    );
  end

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wire_out <= '0;
        wire_oe  <= '0;
      end else begin
        wire_out <= mux_out;
        wire_oe  <= mux_oe;
      end
    end
  end else begin : g_out_comb
    assign wire_out = mux_out;
    assign wire_oe  = mux_oe;
  end

endmodule
